// File: rtl/id_operand_stage.sv
// ID-stage operand fetch and ID/EX pipeline register for the 5-stage LEGv8 pipeline.
// The stage drives both register file read ports and resolves MEM and WB forwarding
// in the same cycle. It flags EX-stage producers so the EX mux can bypass them.
// It also stalls the front end for one cycle on a load-use dependency.
module id_operand_stage #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  // IF/ID instruction and decoded control
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [63:0]       id_pc,
  input  logic              id_reg2loc,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  // register file read ports
  output logic [4:0]        rf_read_reg1,
  output logic [4:0]        rf_read_reg2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  // EX/MEM writer
  input  logic              mem_regwrite,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  // MEM/WB writer (also the register file write port)
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  // hazard control
  input  logic              flush,
  output logic              stall,
  // ID/EX register
  output logic              ex_valid,
  output logic [63:0]       ex_pc,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_fwd_a,
  output logic              ex_fwd_b
);

  // X31 reads as zero and is never a forwarding target.
  localparam logic [4:0] ZERO_REG = 5'd31;

  // Operand selection for one source register. XZR wins over any writer.
  // MEM beats WB because it holds the younger value. WB must be bypassed because
  // the register file only commits it on the coming edge.
  function automatic logic signed [DATA_W-1:0] fwd_operand(
    input logic [4:0]        src,
    input logic [DATA_W-1:0] rf_val,
    input logic              m_we,
    input logic [4:0]        m_rd,
    input logic [DATA_W-1:0] m_val,
    input logic              w_we,
    input logic [4:0]        w_rd,
    input logic [DATA_W-1:0] w_val
  );
    logic signed [DATA_W-1:0] res;
    res = $signed(rf_val);
    if (src == ZERO_REG) begin
      res = '0;
    end else if (m_we && (m_rd == src)) begin
      res = $signed(m_val);
    end else if (w_we && (w_rd == src)) begin
      res = $signed(w_val);
    end
    return res;
  endfunction

  // True when the instruction currently in EX will write register src.
  function automatic logic ex_depends(
    input logic [4:0] src,
    input logic       e_vld,
    input logic       e_we,
    input logic [4:0] e_rd
  );
    return e_vld && e_we && (e_rd == src) && (src != ZERO_REG);
  endfunction

  // ---------------- ID stage (combinational, p0) ----------------
  logic [4:0]               rn_p0;
  logic [4:0]               r2_p0;
  logic signed [DATA_W-1:0] op_a_p0;
  logic signed [DATA_W-1:0] op_b_p0;
  logic                     dep_a_p0;
  logic                     dep_b_p0;
  logic                     hazard_p0;
  logic                     capture_p0;
  logic                     unused_instr_bits;

  assign unused_instr_bits = ^{id_instr[31:21], id_instr[15:10]};

  // Decode source registers, fetch/forward operands and detect hazards.
  always_comb begin
    rn_p0     = id_instr[9:5];
    r2_p0     = id_reg2loc ? id_instr[4:0] : id_instr[20:16];
    op_a_p0   = fwd_operand(rn_p0, rf_data1, mem_regwrite, mem_rd, mem_result,
                            wb_regwrite, wb_rd, wb_data);
    op_b_p0   = fwd_operand(r2_p0, rf_data2, mem_regwrite, mem_rd, mem_result,
                            wb_regwrite, wb_rd, wb_data);
    dep_a_p0  = ex_depends(rn_p0, ex_valid, ex_regwrite, ex_rd);
    dep_b_p0  = ex_depends(r2_p0, ex_valid, ex_regwrite, ex_rd);
    // A load in EX cannot be bypassed yet; the consumer waits one cycle.
    hazard_p0 = id_valid && ex_valid && ex_memread && (dep_a_p0 || dep_b_p0);
    stall     = hazard_p0 && !flush;
    // Neither a flush nor a stall bubble lets the ID instruction into EX.
    capture_p0 = !flush && !hazard_p0;
  end

  assign rf_read_reg1 = rn_p0;
  assign rf_read_reg2 = r2_p0;

  // ---------------- ID/EX boundary (p1) ----------------
  // Control half of ID/EX: bubbles clear valid, write enables and bypass flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_fwd_a    <= 1'b0;
      ex_fwd_b    <= 1'b0;
    end else if (!capture_p0) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_fwd_a    <= 1'b0;
      ex_fwd_b    <= 1'b0;
    end else begin
      ex_valid    <= id_valid;
      ex_regwrite <= id_regwrite && id_valid;
      ex_memread  <= id_memread && id_valid;
      // A load producer would have stalled, so any dependency here is an ALU result.
      ex_fwd_a    <= dep_a_p0 && id_valid;
      ex_fwd_b    <= dep_b_p0 && id_valid;
    end
  end

  // Data half of ID/EX: captured only on a real capture, held across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_pc   <= '0;
      ex_op_a <= '0;
      ex_op_b <= '0;
      ex_imm  <= '0;
      ex_rd   <= '0;
      ex_ctrl <= '0;
    end else if (capture_p0) begin
      ex_pc   <= id_pc;
      ex_op_a <= op_a_p0;
      ex_op_b <= op_b_p0;
      ex_imm  <= id_imm;
      ex_rd   <= id_instr[4:0];
      ex_ctrl <= id_ctrl;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: the driver predicts each ID/EX update from
// the forwarding and hazard rules and queues it; a monitor checks each clock edge.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_reg2loc, id_regwrite, id_memread;
  logic [31:0] id_instr;
  logic [63:0] id_pc, id_imm, rf_data1, rf_data2, mem_result, wb_data;
  logic [7:0]  id_ctrl;
  logic [4:0]  rf_read_reg1, rf_read_reg2, mem_rd, wb_rd;
  logic        mem_regwrite, wb_regwrite, flush, stall;
  logic        ex_valid, ex_regwrite, ex_memread, ex_fwd_a, ex_fwd_b;
  logic [63:0] ex_pc, ex_op_a, ex_op_b, ex_imm;
  logic [4:0]  ex_rd;
  logic [7:0]  ex_ctrl;

  always #5 clk = ~clk;

  id_operand_stage #(.DATA_W(64), .CTRL_W(8)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_reg2loc(id_reg2loc), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_ctrl(ex_ctrl),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b)
  );

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic [7:0]  ctrl;
    logic        fwd_a;
    logic        fwd_b;
  } exp_t;

  exp_t sbq[$];
  exp_t m;          // reference view of what ID/EX holds now
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic last_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ADD-style R format: Rm, Rn, Rd
  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rn,
                                       input logic [4:0] rm);
    return {11'h458, rm, 6'd0, rn, rd};
  endfunction

  // LDUR/STUR-style D format: Rn base, Rt data
  function automatic logic [31:0] mk_d(input logic [4:0] rt, input logic [4:0] rn);
    return {11'h7C2, 9'd0, 2'b00, rn, rt};
  endfunction

  // Value an instruction in ID should see for source register src.
  function automatic logic [63:0] ref_operand(input logic [4:0] src, input logic [63:0] rf);
    if (src == 5'd31) return 64'd0;
    if (mem_regwrite && mem_rd == src) return mem_result;
    if (wb_regwrite && wb_rd == src) return wb_data;
    return rf;
  endfunction

  // The instruction sitting in EX (per the reference) writes src.
  function automatic logic ref_dep(input logic [4:0] src);
    return m.valid && m.regwrite && (m.rd == src) && (src != 5'd31);
  endfunction

  task automatic clr_in();
    id_valid = 0; id_instr = 0; id_pc = 0; id_reg2loc = 0; id_regwrite = 0;
    id_memread = 0; id_imm = 0; id_ctrl = 0; rf_data1 = 0; rf_data2 = 0;
    mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  // Check the combinational outputs, predict the next ID/EX contents, clock once.
  task automatic step();
    logic [4:0] rn, r2;
    logic       hz, st;
    exp_t       n;
    #1;
    rn = id_instr[9:5];
    r2 = id_reg2loc ? id_instr[4:0] : id_instr[20:16];
    hz = id_valid && m.valid && m.memread && (ref_dep(rn) || ref_dep(r2));
    st = hz && !flush;
    chk("rf_read_reg1", {59'd0, rf_read_reg1}, {59'd0, rn});
    chk("rf_read_reg2", {59'd0, rf_read_reg2}, {59'd0, r2});
    chk("stall", {63'd0, stall}, {63'd0, st});
    last_stall = st;
    n = m;
    if (flush || st) begin
      n.valid = 0; n.regwrite = 0; n.memread = 0; n.fwd_a = 0; n.fwd_b = 0;
    end else begin
      n.valid    = id_valid;
      n.pc       = id_pc;
      n.op_a     = ref_operand(rn, rf_data1);
      n.op_b     = ref_operand(r2, rf_data2);
      n.imm      = id_imm;
      n.rd       = id_instr[4:0];
      n.regwrite = id_regwrite && id_valid;
      n.memread  = id_memread && id_valid;
      n.ctrl     = id_ctrl;
      n.fwd_a    = id_valid && ref_dep(rn);
      n.fwd_b    = id_valid && ref_dep(r2);
    end
    m = n;
    sbq.push_back(n);
    @(posedge clk);
    #2;
  endtask

  function automatic logic [4:0] rsel();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 5'd31 : 5'(v);
  endfunction

  // Monitor: after each edge, compare ID/EX against the oldest prediction.
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("ex_valid", {63'd0, ex_valid}, {63'd0, e.valid});
      chk("ex_regwrite", {63'd0, ex_regwrite}, {63'd0, e.regwrite});
      chk("ex_memread", {63'd0, ex_memread}, {63'd0, e.memread});
      chk("ex_fwd_a", {63'd0, ex_fwd_a}, {63'd0, e.fwd_a});
      chk("ex_fwd_b", {63'd0, ex_fwd_b}, {63'd0, e.fwd_b});
      chk("ex_rd", {59'd0, ex_rd}, {59'd0, e.rd});
      chk("ex_pc", ex_pc, e.pc);
      chk("ex_op_a", ex_op_a, e.op_a);
      chk("ex_op_b", ex_op_b, e.op_b);
      chk("ex_imm", ex_imm, e.imm);
      chk("ex_ctrl", {56'd0, ex_ctrl}, {56'd0, e.ctrl});
    end
  end

  initial begin
    reset = 1'b1;
    clr_in();
    m = '0;
    #3;
    chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_ex_fwd", {62'd0, ex_fwd_a, ex_fwd_b}, 64'd0);
    chk("rst_ex_ctl", {62'd0, ex_regwrite, ex_memread}, 64'd0);
    chk("rst_ex_op_a", ex_op_a, 64'd0);
    chk("rst_ex_op_b", ex_op_b, 64'd0);
    chk("rst_ex_pc", ex_pc, 64'd0);
    chk("rst_ex_imm", ex_imm, 64'd0);
    chk("rst_ex_rd_ctrl", {51'd0, ex_rd, ex_ctrl}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // ADD X1,X2,X3 from the register file
    id_valid = 1; id_regwrite = 1; id_instr = mk_r(5'd1, 5'd2, 5'd3);
    id_pc = 64'h400; id_imm = 64'h10; id_ctrl = 8'h5A;
    rf_data1 = 64'd5; rf_data2 = 64'd7;
    step();
    chk("add_op_a", ex_op_a, 64'd5);
    chk("add_op_b", ex_op_b, 64'd7);
    chk("add_rd", {59'd0, ex_rd}, 64'd1);
    chk("add_valid", {63'd0, ex_valid}, 64'd1);

    // MEM has priority over WB; WB beats the stale register file
    id_instr = mk_r(5'd9, 5'd2, 5'd3); rf_data1 = 64'h55;
    mem_regwrite = 1; mem_rd = 5'd2; mem_result = 64'hAA;
    wb_regwrite = 1; wb_rd = 5'd2; wb_data = 64'hBB;
    step();
    chk("mem_prio", ex_op_a, 64'hAA);
    mem_regwrite = 0;
    step();
    chk("wb_bypass", ex_op_a, 64'hBB);
    wb_regwrite = 0;

    // X31 reads zero even with a writer aimed at it
    id_instr = mk_r(5'd9, 5'd31, 5'd3); rf_data1 = 64'h77;
    mem_regwrite = 1; mem_rd = 5'd31; mem_result = 64'hCC;
    step();
    chk("xzr_operand", ex_op_a, 64'd0);
    mem_regwrite = 0;

    // A load targeting X31 in EX causes no stall and no bypass
    id_instr = mk_d(5'd31, 5'd1); id_memread = 1;
    step();
    id_instr = mk_r(5'd2, 5'd31, 5'd31); id_memread = 0;
    step();
    chk("xzr_fwd", {62'd0, ex_fwd_a, ex_fwd_b}, 64'd0);
    chk("xzr_valid", {63'd0, ex_valid}, 64'd1);

    // ADD X4 then SUB X5,X4,X4: both operands bypassed from EX
    id_instr = mk_r(5'd4, 5'd1, 5'd2);
    step();
    id_instr = mk_r(5'd5, 5'd4, 5'd4);
    step();
    chk("ex_dep_fwd", {62'd0, ex_fwd_a, ex_fwd_b}, 64'd3);

    // LDUR X6 then STUR X6,[X7]: one bubble, then MEM forwarding supplies X6
    id_instr = mk_d(5'd6, 5'd1); id_memread = 1; id_regwrite = 1;
    step();
    id_instr = mk_d(5'd6, 5'd7); id_memread = 0; id_regwrite = 0; id_reg2loc = 1;
    #1;
    chk("lu_stall", {63'd0, stall}, 64'd1);
    step();
    chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
    mem_regwrite = 1; mem_rd = 5'd6; mem_result = 64'h1234; rf_data2 = 64'hDEAD;
    step();
    chk("lu_fwd_b", ex_op_b, 64'h1234);
    chk("lu_valid", {63'd0, ex_valid}, 64'd1);
    mem_regwrite = 0; id_reg2loc = 0;

    // Load-use hazard together with flush: no stall, bubble
    id_instr = mk_d(5'd6, 5'd1); id_memread = 1; id_regwrite = 1;
    step();
    id_instr = mk_r(5'd8, 5'd6, 5'd1); id_memread = 0; flush = 1;
    step();
    chk("flush_valid", {63'd0, ex_valid}, 64'd0);
    flush = 0;

    // Reset during a stall drops stall at once
    id_instr = mk_d(5'd6, 5'd1); id_memread = 1; id_regwrite = 1;
    step();
    id_instr = mk_r(5'd8, 5'd6, 5'd6); id_memread = 0;
    #1;
    chk("pre_rst_stall", {63'd0, stall}, 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_stall", {63'd0, stall}, 64'd0);
    chk("rst_mid_valid", {63'd0, ex_valid}, 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    m = '0;

    // Randomized traffic with a small register set to provoke collisions
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        id_valid    = ($urandom_range(0, 9) < 8);
        id_instr    = $urandom;
        id_instr[4:0]   = rsel();
        id_instr[9:5]   = rsel();
        id_instr[20:16] = rsel();
        id_reg2loc  = $urandom_range(0, 1) == 1;
        id_regwrite = ($urandom_range(0, 9) < 7);
        id_memread  = ($urandom_range(0, 9) < 3);
        id_pc       = {$urandom, $urandom};
        id_imm      = {$urandom, $urandom};
        id_ctrl     = 8'($urandom);
      end
      rf_data1     = {$urandom, $urandom};
      rf_data2     = {$urandom, $urandom};
      mem_regwrite = $urandom_range(0, 1) == 1;
      mem_rd       = rsel();
      mem_result   = {$urandom, $urandom};
      wb_regwrite  = $urandom_range(0, 1) == 1;
      wb_rd        = rsel();
      wb_data      = {$urandom, $urandom};
      flush        = ($urandom_range(0, 9) == 0);
      step();
    end

    clr_in();
    step();
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
